// File: rtl/spc_ctl.sv
// spc_ctl: strobe sequencer, read latch and depth tracker around the SPC stack.
// Optional: define SPC_BOUNDS_TRAP_EN for the sticky overflow/underflow flag.
module spc_ctl #(
   parameter int DW    = 19,
   parameter int PCW   = 14,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     state_decode,
   input  logic                     state_fetch,
   input  logic                     op_push,
   input  logic                     op_pop,
   input  logic                     op_write_l,
   input  logic [PCW-1:0]           ret_pc,
   input  logic                     ret_flag,
   input  logic [31:0]              l,
   input  logic [DW-1:0]            spco,
   output logic [DW-1:0]            spcw,
   output logic                     swp,
   output logic                     srp,
   output logic                     spcnt,
   output logic                     spush,
   output logic [DW-1:0]            spc_lat,
   output logic                     spc_valid,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     spc_err
);

   localparam int AW = $clog2(DEPTH) + 1;
   localparam logic [AW-1:0] FULL = AW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_WAIT,
      S_POP_RD,
      S_POP_LAT,
      S_POP_WAIT
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            w_push;
   logic            w_dec;
   logic            w_dec_push;
   logic            w_dec_pop;
   logic            w_fet_push;
   logic            w_fet_pop;
   logic [DW-1:0]   r_lat;
   logic            r_valid;
   logic [AW-1:0]   r_depth;
   logic            w_unused;

   // A call and a destination-SPC write share one sequence; push beats pop.
   assign w_push     = op_push | op_write_l;
   assign w_dec      = reset & (r_state == S_IDLE) & state_decode;
   assign w_dec_push = w_dec & w_push;
   assign w_dec_pop  = w_dec & op_pop & ~w_push;
   assign w_fet_push = reset & (r_state == S_PUSH_WAIT) & state_fetch;
   assign w_fet_pop  = reset & (r_state == S_POP_WAIT) & state_fetch;

   assign w_unused = ^l[31:DW];

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: fetch is only honoured once the read data is latched.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (state_decode && w_push) begin
               w_next = S_PUSH_WAIT;
            end else if (state_decode && op_pop) begin
               w_next = S_POP_RD;
            end
         end
         S_PUSH_WAIT: begin
            if (state_fetch) begin
               w_next = S_IDLE;
            end
         end
         S_POP_RD:  w_next = S_POP_LAT;
         S_POP_LAT: w_next = S_POP_WAIT;
         S_POP_WAIT: begin
            if (state_fetch) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Memory strobes; gated by reset so nothing escapes while it is held.
   always_comb begin
      swp   = w_dec_push;
      srp   = w_dec_pop;
      spcnt = w_dec_push | w_fet_push | w_fet_pop;
      spush = w_dec_push | w_fet_push;
      busy  = w_dec_pop | (reset & (r_state == S_POP_RD));
      spcw  = '0;
      if (reset) begin
         if (op_write_l) begin
            spcw = l[DW-1:0];
         end else begin
            spcw = {{(DW-PCW-1){1'b0}}, ret_flag, ret_pc};
         end
      end
   end

   // Popped-word latch and saturating depth counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_lat   <= '0;
         r_valid <= 1'b0;
         r_depth <= '0;
      end else begin
         if (w_dec_pop) begin
            r_valid <= 1'b0;
         end
         if (r_state == S_POP_LAT) begin
            r_lat   <= spco;
            r_valid <= 1'b1;
         end
         if (w_fet_push && (r_depth != FULL)) begin
            r_depth <= r_depth + 1'b1;
         end
         if (w_fet_pop && (r_depth != '0)) begin
            r_depth <= r_depth - 1'b1;
         end
      end
   end

   assign spc_lat   = r_lat;
   assign spc_valid = r_valid;
   assign depth     = r_depth;

`ifdef SPC_BOUNDS_TRAP_EN
   logic r_err;
   logic w_err_evt;

   assign w_err_evt = w_dec & ((w_push & (op_pop | (r_depth == FULL)))
                             | (op_pop & ~w_push & (r_depth == '0)));

   // Sticky bounds error; the stack operation itself still proceeds.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_err_evt) begin
         r_err <= 1'b1;
      end
   end

   assign spc_err = r_err;
`else
   assign spc_err = 1'b0;
`endif

endmodule

// File: tb/tb_spc_ctl.sv
// tb_spc_ctl: directed + random call/popj sequences against a stack model.
// Build with SPC_BOUNDS_TRAP_EN defined to expect the sticky error flag.
module tb_spc_ctl;

   localparam int DW  = 19;
   localparam int PCW = 14;
`ifdef SPC_BOUNDS_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            state_decode = 1'b0;
   logic            state_fetch = 1'b0;
   logic            op_push = 1'b0;
   logic            op_pop = 1'b0;
   logic            op_write_l = 1'b0;
   logic [PCW-1:0]  ret_pc = '0;
   logic            ret_flag = 1'b0;
   logic [31:0]     l = '0;
   logic [DW-1:0]   spco = '0;
   logic [DW-1:0]   spcw;
   logic            swp, srp, spcnt, spush;
   logic [DW-1:0]   spc_lat;
   logic            spc_valid, busy, spc_err;
   logic [5:0]      depth;

   int n_chk = 0;
   int n_fail = 0;

   // environment stack memory, driven only by the DUT strobes
   logic [DW-1:0] env_mem [32];
   logic [4:0]    env_ptr = '0;

   // reference model, driven only by the operations the bench issues
   logic [DW-1:0] ref_mem [32];
   int            ref_ptr = 0;
   int            ref_depth = 0;
   bit            ref_err = 1'b0;
   bit            ref_valid = 1'b0;
   logic [DW-1:0] ref_lat = '0;

   spc_ctl dut (
      .clk(clk), .reset(reset),
      .state_decode(state_decode), .state_fetch(state_fetch),
      .op_push(op_push), .op_pop(op_pop), .op_write_l(op_write_l),
      .ret_pc(ret_pc), .ret_flag(ret_flag), .l(l), .spco(spco),
      .spcw(spcw), .swp(swp), .srp(srp), .spcnt(spcnt), .spush(spush),
      .spc_lat(spc_lat), .spc_valid(spc_valid), .busy(busy),
      .depth(depth), .spc_err(spc_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (swp) env_mem[env_ptr + 5'd1] <= spcw;
      if (srp) spco <= env_mem[env_ptr];
      if (spcnt && !swp) env_ptr <= spush ? env_ptr + 5'd1 : env_ptr - 5'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic strb(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, swp, srp, spcnt, spush}, {28'd0, exp});
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_depth"}, {26'd0, depth}, ref_depth);
      chk({tag, "_err"}, {31'd0, spc_err}, {31'd0, ref_err});
      chk({tag, "_valid"}, {31'd0, spc_valid}, {31'd0, ref_valid});
      chk({tag, "_lat"}, {13'd0, spc_lat}, {13'd0, ref_lat});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_bits"}, {25'd0, swp, srp, spcnt, spush, busy,
                           spc_valid, spc_err}, 32'd0);
      chk({tag, "_spcw"}, {13'd0, spcw}, 32'd0);
      chk({tag, "_lat"}, {13'd0, spc_lat}, 32'd0);
      chk({tag, "_depth"}, {26'd0, depth}, 32'd0);
   endtask

   task automatic reset_model();
      ref_depth = 0;
      ref_err = 1'b0;
      ref_valid = 1'b0;
      ref_lat = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      nxt();
      nxt();
      @(negedge clk);
      chk_zero("rst");
      nxt();
      reset = 1'b1;
      reset_model();
   endtask

   // call (wl=0) or destination-SPC write (wl=1); optional conflicting pop
   task automatic do_push(input bit wl, input bit also_pop,
                          input logic [PCW-1:0] pc, input bit flag,
                          input logic [31:0] lw);
      logic [DW-1:0] word;
      word = wl ? lw[DW-1:0] : {4'd0, flag, pc};
      if (ref_depth == 32 || also_pop) ref_err = ref_err | TRAP;
      state_decode = 1'b1;
      op_push = !wl;
      op_write_l = wl;
      op_pop = also_pop;
      ret_pc = pc;
      ret_flag = flag;
      l = lw;
      @(negedge clk);
      strb("push_dec", 4'b1011);
      chk("push_spcw", {13'd0, spcw}, {13'd0, word});
      chk("push_busy", {31'd0, busy}, 32'd0);
      nxt();
      state_decode = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         strb("push_wait", 4'b0000);
         nxt();
      end
      state_fetch = 1'b1;
      @(negedge clk);
      strb("push_fet", 4'b0011);
      nxt();
      state_fetch = 1'b0;
      op_push = 1'b0;
      op_write_l = 1'b0;
      op_pop = 1'b0;
      ref_ptr = (ref_ptr + 1) % 32;
      ref_mem[ref_ptr] = word;
      if (ref_depth < 32) ref_depth++;
      @(negedge clk);
      chk_state("push_end");
      nxt();
   endtask

   task automatic do_pop(input bit early);
      logic [DW-1:0] exp;
      exp = ref_mem[ref_ptr];
      if (ref_depth == 0) ref_err = ref_err | TRAP;
      state_decode = 1'b1;
      op_pop = 1'b1;
      @(negedge clk);
      strb("pop_dec", 4'b0100);
      chk("pop_busy0", {31'd0, busy}, 32'd1);
      nxt();
      state_decode = 1'b0;
      state_fetch = early;
      @(negedge clk);
      strb("pop_rd", 4'b0000);
      chk("pop_busy1", {31'd0, busy}, 32'd1);
      chk("pop_vclr", {31'd0, spc_valid}, 32'd0);
      nxt();
      state_fetch = 1'b0;
      @(negedge clk);
      strb("pop_lat", 4'b0000);
      chk("pop_busy2", {31'd0, busy}, 32'd0);
      chk("pop_dhold", {26'd0, depth}, ref_depth);
      nxt();
      state_fetch = 1'b1;
      @(negedge clk);
      strb("pop_fet", 4'b0010);
      chk("pop_word", {13'd0, spc_lat}, {13'd0, exp});
      chk("pop_valid", {31'd0, spc_valid}, 32'd1);
      nxt();
      state_fetch = 1'b0;
      op_pop = 1'b0;
      ref_ptr = (ref_ptr + 31) % 32;
      if (ref_depth > 0) ref_depth--;
      ref_valid = 1'b1;
      ref_lat = exp;
      @(negedge clk);
      chk_state("pop_end");
      nxt();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         env_mem[i] = '0;
         ref_mem[i] = '0;
      end
      #1;
      do_reset();

      // reset abandons a pop sitting in its read cycle
      state_decode = 1'b1;
      op_pop = 1'b1;
      nxt();
      state_decode = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      strb("mid_rst_strb", 4'b0000);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      nxt();
      @(negedge clk);
      chk_zero("mid_rst");
      nxt();
      reset = 1'b1;
      op_pop = 1'b0;
      reset_model();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         strb("post_rst", 4'b0000);
         chk("post_rst_busy", {31'd0, busy}, 32'd0);
         nxt();
      end

      // directed call / popj / destination write
      do_push(1'b0, 1'b0, 14'h1234, 1'b1, 32'd0);
      do_pop(1'b0);
      do_push(1'b1, 1'b0, 14'h0, 1'b0, 32'hFFFA_BCDE);
      do_pop(1'b0);

      // random mix, depth kept off the bounds
      for (int i = 0; i < 24; i++) begin
         int k;
         k = $urandom_range(0, 2);
         if (k == 2 && ref_depth > 0)
            do_pop(1'($urandom_range(0, 1)));
         else
            do_push(1'(k == 1), 1'b0, 14'($urandom), 1'($urandom),
                    $urandom);
      end

      // overflow: 33 calls, depth saturates
      do_reset();
      for (int i = 0; i < 33; i++)
         do_push(1'b0, 1'b0, 14'($urandom), 1'($urandom), 32'd0);
      chk("sat_depth", {26'd0, depth}, 32'd32);
      chk("ovf_err", {31'd0, spc_err}, {31'd0, TRAP});
      for (int i = 0; i < 32; i++) do_pop(1'b0);

      // underflow: pop at depth 0 with a clean error flag
      do_reset();
      do_pop(1'b0);
      chk("unf_err", {31'd0, spc_err}, {31'd0, TRAP});

      // early fetch is ignored, conflict resolves as a push
      do_reset();
      do_push(1'b0, 1'b0, 14'h0ABC, 1'b0, 32'd0);
      do_pop(1'b1);
      do_push(1'b0, 1'b1, 14'h3001, 1'b1, 32'd0);
      chk("conf_depth", {26'd0, depth}, 32'd1);
      do_pop(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
